midi_event_parser: RTL and testbench
====================================

# midi_event_parser

Converts the serial MIDI byte stream from the UART receiver into single-cycle note events for the synthesizer core. Decodes Note On, Note Off, Polyphonic Key Pressure and Channel Pressure, handles running status, and discards every other message. Sits between the UART byte receiver and the synth's note-event FIFO write port.

## Interface
- CHANNEL_MASK, 16'hFFFF, bit n set = events on MIDI channel n are emitted; masked channels are parsed and then dropped.
- clk32  in  1  system clock, 32 MHz
- rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received MIDI byte
- note_pressed  out  1  one-cycle pulse: Note On with velocity ≠ 0
- note_released  out  1  one-cycle pulse: Note Off, or Note On with velocity 0
- note_keypress  out  1  one-cycle pulse: Polyphonic Key Pressure
- note_channelpress  out  1  one-cycle pulse: Channel Pressure
- note_interface  out  7  note number of the last event
- velocity  out  7  velocity or pressure value of the last event
- channel  out  4  channel of the last event
- drop_cnt  out  8  saturating count of discarded data bytes

## Operation
- Byte classes:
  - 0x00–0x7F: data byte.
  - 0x80–0xEF: channel status byte.
  - 0xF0–0xF7: system common byte.
  - 0xF8–0xFF: realtime byte.
- Realtime bytes are ignored in every state. They do not change state, the running status or partial data.
- FSM states: WAIT_STATUS, DATA1, DATA2, SYSEX.
  - Channel status byte, any state: latch it as the running status (rs, with rs_valid=1); clear partial data.
    - Next state is DATA1 for every status type.
    - Types 8/9/A/B/E expect 2 data bytes; C/D expect 1.
  - 0xF0: rs_valid=0, go to SYSEX. Data bytes in SYSEX are ignored and are not counted.
  - Any other 0xF1–0xF7: rs_valid=0, go to WAIT_STATUS.
  - Data byte in WAIT_STATUS:
    - If rs_valid=1, treat it as the first data byte of rs and handle it as in DATA1 (running status).
    - Otherwise discard it and increment drop_cnt.
  - Data byte in DATA1:
    - 1-byte type: complete the message and go to WAIT_STATUS.
    - 2-byte type: store the byte as d1 and go to DATA2.
  - Data byte in DATA2: complete the message with d1 and this byte, then go to WAIT_STATUS.
- Message completion, only when CHANNEL_MASK[rs[3:0]]=1:
  - 0x8n: note_released; note_interface=d1; velocity=d2.
  - 0x9n with d2≠0: note_pressed. With d2=0: note_released, velocity=0.
  - 0xAn: note_keypress; note_interface=d1; velocity=d2.
  - 0xDn: note_channelpress; note_interface=0; velocity=d1.
  - 0xBn, 0xCn, 0xEn: no output.
  - In all emitting cases channel=rs[3:0].
- drop_cnt saturates at 0xFF and is cleared only by reset.
- Reset values: all pulses 0, note_interface=0, velocity=0, channel=0, drop_cnt=0. State is WAIT_STATUS with rs_valid=0.
- Reset asserted mid-message loses the partial message. No event is emitted afterwards for it.

## Timing
- Latency: an event pulse is high in the cycle after the rx_valid cycle that carried the final data byte. The pulse lasts exactly one cycle.
- note_interface, velocity and channel update in the same cycle as the pulse. They hold until the next emitted event.
- At most one pulse output is high in any cycle.
- rx_valid may be asserted on consecutive cycles. The parser accepts one byte per cycle and needs no backpressure.
- A realtime byte between data bytes adds no latency beyond its own cycle.

## Configuration
- MIDI_RUNNING_STATUS_EN
  - Defined: running status works as described under Operation.
  - Undefined: rs_valid is cleared whenever a message completes. A data byte arriving in WAIT_STATUS is always discarded and counted in drop_cnt.

## Test plan
- Bytes 0x93,0x3C,0x64 → note_pressed pulse 1 cycle after the 0x64 strobe, with note_interface=0x3C, velocity=0x64, channel=3.
- Bytes 0x90,0x40,0x50, then 0x40,0x00 (running status) → note_pressed (0x40, 0x50, ch0), then note_released (0x40, velocity 0, ch0). Without MIDI_RUNNING_STATUS_EN: first event only, and drop_cnt=2.
- Bytes 0x91,0x3C,0xF8,0x7F → 0xF8 ignored; note_pressed with note 0x3C, velocity 0x7F, ch1.
- Bytes 0xD5,0x20, then 0xA2,0x30,0x40 → note_channelpress (note 0, velocity 0x20, ch5), then note_keypress (0x30, 0x40, ch2).
- Bytes 0xF0,0x7E,0x01,0xF7, then 0x45 → no events; drop_cnt=1. Also: CHANNEL_MASK=16'h0001 with 0x82,0x3C,0x00 → no event.
- 300 stray data bytes after reset → drop_cnt=0xFF. Drive rst_n low between 0x90 and 0x3C, then 0x40 after release → no event; drop_cnt=1.

Source files
------------

// File: rtl/midi_event_parser.sv
// MIDI byte-stream parser: turns UART bytes into one-cycle note events (on/off, key and channel pressure).
// Build option MIDI_RUNNING_STATUS_EN enables running status; without it a data byte after a completed message is dropped.
module midi_event_parser #(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic       note_channelpress,
    output logic [6:0] note_interface,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic [7:0] drop_cnt,
    output logic [1:0] state_dbg,
    output logic       rs_valid_dbg
);

    // rx_valid is a single-cycle strobe with no ready: every strobed byte is consumed in that cycle.
    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        DATA1       = 2'd1,
        DATA2       = 2'd2,
        SYSEX       = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] rs;
    logic       rs_valid;
    logic [6:0] d1;

    logic       is_data;
    logic       is_chan_status;
    logic       is_sys_common;
    logic       rs_allow;
    logic       one_byte;
    logic       accept_first;
    logic       complete;
    logic       emit;
    logic       drop;
    logic [6:0] c_d1;
    logic [6:0] c_d2;

    always_comb begin
        is_data        = rx_valid && !rx_data[7];
        is_chan_status = rx_valid && rx_data[7] && (rx_data[7:4] != 4'hF);
        // 0xF0-0xF7 only; 0xF8-0xFF (realtime) fall through every branch untouched
        is_sys_common  = rx_valid && (rx_data[7:3] == 5'b11110);
`ifdef MIDI_RUNNING_STATUS_EN
        rs_allow       = rs_valid;
`else
        rs_allow       = 1'b0;
`endif
        one_byte       = (rs[7:4] == 4'hC) || (rs[7:4] == 4'hD);
        accept_first   = is_data && ((state == DATA1) || ((state == WAIT_STATUS) && rs_allow));
        complete       = (accept_first && one_byte) || (is_data && (state == DATA2));
        drop           = is_data && (state == WAIT_STATUS) && !rs_allow;
        c_d1           = (state == DATA2) ? d1 : rx_data[6:0];
        c_d2           = (state == DATA2) ? rx_data[6:0] : 7'd0;
        emit           = complete && CHANNEL_MASK[rs[3:0]];
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            state             <= WAIT_STATUS;
            rs                <= 8'h00;
            rs_valid          <= 1'b0;
            d1                <= 7'd0;
            note_pressed      <= 1'b0;
            note_released     <= 1'b0;
            note_keypress     <= 1'b0;
            note_channelpress <= 1'b0;
            note_interface    <= 7'd0;
            velocity          <= 7'd0;
            channel           <= 4'd0;
            drop_cnt          <= 8'h00;
        end else begin
            note_pressed      <= 1'b0;
            note_released     <= 1'b0;
            note_keypress     <= 1'b0;
            note_channelpress <= 1'b0;

            if (is_chan_status) begin
                rs       <= rx_data;
                rs_valid <= 1'b1;
                d1       <= 7'd0;
                state    <= DATA1;
            end else if (is_sys_common) begin
                rs_valid <= 1'b0;
                state    <= (rx_data == 8'hF0) ? SYSEX : WAIT_STATUS;
            end else if (is_data) begin
                if (drop) begin
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end else if (accept_first && !one_byte) begin
                    d1    <= rx_data[6:0];
                    state <= DATA2;
                end
                if (complete) begin
                    state <= WAIT_STATUS;
`ifndef MIDI_RUNNING_STATUS_EN
                    rs_valid <= 1'b0;
`endif
                end
            end

            // Masked channels and B/C/E messages complete silently and leave the event fields alone
            if (emit) begin
                case (rs[7:4])
                    4'h8: begin
                        note_released  <= 1'b1;
                        note_interface <= c_d1;
                        velocity       <= c_d2;
                        channel        <= rs[3:0];
                    end
                    4'h9: begin
                        note_pressed   <= (c_d2 != 7'd0);
                        note_released  <= (c_d2 == 7'd0);
                        note_interface <= c_d1;
                        velocity       <= c_d2;
                        channel        <= rs[3:0];
                    end
                    4'hA: begin
                        note_keypress  <= 1'b1;
                        note_interface <= c_d1;
                        velocity       <= c_d2;
                        channel        <= rs[3:0];
                    end
                    4'hD: begin
                        note_channelpress <= 1'b1;
                        note_interface    <= 7'd0;
                        velocity          <= c_d1;
                        channel           <= rs[3:0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign state_dbg    = state;
    assign rs_valid_dbg = rs_valid;

endmodule

// File: tb/tb_midi_event_parser.sv
// Directed bench for midi_event_parser; expectations follow MIDI_RUNNING_STATUS_EN when it is defined.
`timescale 1ns/1ps
module tb_midi_event_parser;

    logic       clk32 = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       note_pressed, note_released, note_keypress, note_channelpress;
    logic [6:0] note_interface, velocity;
    logic [3:0] channel;
    logic [7:0] drop_cnt;
    logic [1:0] state_dbg;
    logic       rs_valid_dbg;

    logic       m_pressed, m_released, m_keypress, m_channelpress;
    logic [6:0] m_note, m_velocity;
    logic [3:0] m_channel;
    logic [7:0] m_drop_cnt;
    logic [1:0] m_state_dbg;
    logic       m_rs_valid_dbg;

    logic [21:0] ev_obs;
    logic [21:0] m_ev_obs;

    int n_cmp = 0;
    int n_err = 0;
    int ev_cnt = 0;
    int m_ev_cnt = 0;
    int ev_before;
    int m_ev_before;

    midi_event_parser u_dut (
        .clk32(clk32), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .note_pressed(note_pressed), .note_released(note_released),
        .note_keypress(note_keypress), .note_channelpress(note_channelpress),
        .note_interface(note_interface), .velocity(velocity), .channel(channel),
        .drop_cnt(drop_cnt), .state_dbg(state_dbg), .rs_valid_dbg(rs_valid_dbg)
    );

    midi_event_parser #(.CHANNEL_MASK(16'h0001)) u_mask (
        .clk32(clk32), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .note_pressed(m_pressed), .note_released(m_released),
        .note_keypress(m_keypress), .note_channelpress(m_channelpress),
        .note_interface(m_note), .velocity(m_velocity), .channel(m_channel),
        .drop_cnt(m_drop_cnt), .state_dbg(m_state_dbg), .rs_valid_dbg(m_rs_valid_dbg)
    );

    // clock / reset
    always #15.625 clk32 = ~clk32;

    assign ev_obs   = {note_pressed, note_released, note_keypress, note_channelpress,
                       note_interface, velocity, channel};
    assign m_ev_obs = {m_pressed, m_released, m_keypress, m_channelpress,
                       m_note, m_velocity, m_channel};

    // event monitor: counts pulses and checks that no two pulses overlap
    always @(posedge clk32) begin
        #1;
        if (ev_obs[21:18] != 4'b0000) begin
            ev_cnt++;
            n_cmp++;
            if (!$onehot0(ev_obs[21:18])) begin
                n_err++;
                $display("FAIL onehot_pulse: got %b required at most one bit set", ev_obs[21:18]);
            end
        end
        if (m_ev_obs[21:18] != 4'b0000) begin
            m_ev_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input logic [7:0] b);
        @(negedge clk32);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle();
        @(negedge clk32);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk32);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk32);
        @(negedge clk32);
        rst_n = 1'b1;
        @(negedge clk32);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (ev_obs !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", ev_obs);
        end
        n_cmp++;
        if (drop_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL reset_drop_cnt: got %h required 00", drop_cnt);
        end
        n_cmp++;
        if (state_dbg !== 2'd0 || rs_valid_dbg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got %0d/%b required 0/0", state_dbg, rs_valid_dbg);
        end
    endtask

    task automatic test_note_on();
        do_reset();
        ev_before = ev_cnt;
        drive(8'h93); idle();
        n_cmp++;
        if (state_dbg !== 2'd1 || rs_valid_dbg !== 1'b1) begin
            n_err++;
            $display("FAIL status_latch: got %0d/%b required 1/1", state_dbg, rs_valid_dbg);
        end
        drive(8'h3C); idle();
        drive(8'h64); idle();
        n_cmp++;
        if (ev_obs !== {4'b1000, 7'h3C, 7'h64, 4'd3}) begin
            n_err++;
            $display("FAIL note_on_event: got %h required %h", ev_obs, {4'b1000, 7'h3C, 7'h64, 4'd3});
        end
        idle();
        n_cmp++;
        if (ev_obs !== {4'b0000, 7'h3C, 7'h64, 4'd3}) begin
            n_err++;
            $display("FAIL note_on_hold: got %h required %h", ev_obs, {4'b0000, 7'h3C, 7'h64, 4'd3});
        end
        n_cmp++;
        if (ev_cnt - ev_before !== 1) begin
            n_err++;
            $display("FAIL note_on_count: got %0d required 1", ev_cnt - ev_before);
        end
    endtask

    task automatic test_running_status();
        do_reset();
        ev_before = ev_cnt;
        drive(8'h90); idle();
        drive(8'h40); idle();
        drive(8'h50); idle();
        n_cmp++;
        if (ev_obs !== {4'b1000, 7'h40, 7'h50, 4'd0}) begin
            n_err++;
            $display("FAIL rs_first_event: got %h required %h", ev_obs, {4'b1000, 7'h40, 7'h50, 4'd0});
        end
        drive(8'h40); idle();
        drive(8'h00); idle();
`ifdef MIDI_RUNNING_STATUS_EN
        n_cmp++;
        if (ev_obs !== {4'b0100, 7'h40, 7'h00, 4'd0}) begin
            n_err++;
            $display("FAIL rs_second_event: got %h required %h", ev_obs, {4'b0100, 7'h40, 7'h00, 4'd0});
        end
        n_cmp++;
        if (drop_cnt !== 8'd0 || ev_cnt - ev_before !== 2) begin
            n_err++;
            $display("FAIL rs_counts: got drop %0d events %0d required 0 and 2", drop_cnt, ev_cnt - ev_before);
        end
`else
        n_cmp++;
        if (ev_obs !== {4'b0000, 7'h40, 7'h50, 4'd0}) begin
            n_err++;
            $display("FAIL nors_fields_hold: got %h required %h", ev_obs, {4'b0000, 7'h40, 7'h50, 4'd0});
        end
        n_cmp++;
        if (drop_cnt !== 8'd2 || ev_cnt - ev_before !== 1) begin
            n_err++;
            $display("FAIL nors_counts: got drop %0d events %0d required 2 and 1", drop_cnt, ev_cnt - ev_before);
        end
`endif
    endtask

    task automatic test_interrupted_message();
        do_reset();
        ev_before = ev_cnt;
        drive(8'h90); idle();
        drive(8'h40); idle();
        drive(8'h80); idle();
        drive(8'h41); idle();
        drive(8'h22); idle();
        n_cmp++;
        if (ev_obs !== {4'b0100, 7'h41, 7'h22, 4'd0} || ev_cnt - ev_before !== 1) begin
            n_err++;
            $display("FAIL interrupt_event: got %h / %0d events required %h / 1",
                     ev_obs, ev_cnt - ev_before, {4'b0100, 7'h41, 7'h22, 4'd0});
        end
    endtask

    task automatic test_realtime();
        do_reset();
        ev_before = ev_cnt;
        drive(8'hF8);
        drive(8'h91);
        drive(8'h3C);
        drive(8'hF8);
        idle();
        n_cmp++;
        if (state_dbg !== 2'd2 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL realtime_state: got state %0d drop %0d required 2 and 0", state_dbg, drop_cnt);
        end
        drive(8'h7F); idle();
        n_cmp++;
        if (ev_obs !== {4'b1000, 7'h3C, 7'h7F, 4'd1} || ev_cnt - ev_before !== 1) begin
            n_err++;
            $display("FAIL realtime_event: got %h / %0d events required %h / 1",
                     ev_obs, ev_cnt - ev_before, {4'b1000, 7'h3C, 7'h7F, 4'd1});
        end
    endtask

    task automatic test_pressure();
        do_reset();
        drive(8'hD5); idle();
        drive(8'h20); idle();
        n_cmp++;
        if (ev_obs !== {4'b0001, 7'h00, 7'h20, 4'd5}) begin
            n_err++;
            $display("FAIL chan_pressure: got %h required %h", ev_obs, {4'b0001, 7'h00, 7'h20, 4'd5});
        end
        drive(8'hA2); idle();
        drive(8'h30); idle();
        drive(8'h40); idle();
        n_cmp++;
        if (ev_obs !== {4'b0010, 7'h30, 7'h40, 4'd2}) begin
            n_err++;
            $display("FAIL key_pressure: got %h required %h", ev_obs, {4'b0010, 7'h30, 7'h40, 4'd2});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(8'hD5);
        drive(8'h20);
        drive(8'hA2);
        n_cmp++;
        if (ev_obs !== {4'b0001, 7'h00, 7'h20, 4'd5}) begin
            n_err++;
            $display("FAIL b2b_chan_pressure: got %h required %h", ev_obs, {4'b0001, 7'h00, 7'h20, 4'd5});
        end
        drive(8'h30);
        n_cmp++;
        if (ev_obs !== {4'b0000, 7'h00, 7'h20, 4'd5}) begin
            n_err++;
            $display("FAIL b2b_single_cycle: got %h required %h", ev_obs, {4'b0000, 7'h00, 7'h20, 4'd5});
        end
        drive(8'h40);
        idle();
        n_cmp++;
        if (ev_obs !== {4'b0010, 7'h30, 7'h40, 4'd2}) begin
            n_err++;
            $display("FAIL b2b_key_pressure: got %h required %h", ev_obs, {4'b0010, 7'h30, 7'h40, 4'd2});
        end
    endtask

    task automatic test_silent_types();
        do_reset();
        ev_before = ev_cnt;
        drive(8'hB0); drive(8'h07); drive(8'h64);
        drive(8'hC1); drive(8'h05); drive(8'h06);
        drive(8'hE0); drive(8'h00); drive(8'h40);
        idle(); idle();
        n_cmp++;
        if (ev_obs !== 22'd0 || ev_cnt - ev_before !== 0) begin
            n_err++;
            $display("FAIL silent_no_event: got %h / %0d events required 0 / 0", ev_obs, ev_cnt - ev_before);
        end
        n_cmp++;
`ifdef MIDI_RUNNING_STATUS_EN
        if (drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL silent_drop: got %0d required 0", drop_cnt);
        end
`else
        if (drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL silent_drop: got %0d required 1", drop_cnt);
        end
`endif
    endtask

    task automatic test_sysex();
        do_reset();
        ev_before = ev_cnt;
        drive(8'hF0); idle();
        n_cmp++;
        if (state_dbg !== 2'd3 || rs_valid_dbg !== 1'b0) begin
            n_err++;
            $display("FAIL sysex_state: got %0d/%b required 3/0", state_dbg, rs_valid_dbg);
        end
        drive(8'h7E); drive(8'h01); drive(8'hF7); drive(8'h45);
        idle(); idle();
        n_cmp++;
        if (drop_cnt !== 8'd1 || ev_cnt - ev_before !== 0) begin
            n_err++;
            $display("FAIL sysex_drop: got drop %0d events %0d required 1 and 0", drop_cnt, ev_cnt - ev_before);
        end
        drive(8'h92); drive(8'hF3); drive(8'h3C); idle(); idle();
        n_cmp++;
        if (state_dbg !== 2'd0 || drop_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL syscommon_cancel: got state %0d drop %0d required 0 and 2", state_dbg, drop_cnt);
        end
    endtask

    task automatic test_channel_mask();
        do_reset();
        m_ev_before = m_ev_cnt;
        drive(8'h82); idle();
        drive(8'h3C); idle();
        drive(8'h00); idle();
        n_cmp++;
        if (m_ev_obs !== 22'd0 || m_ev_cnt - m_ev_before !== 0) begin
            n_err++;
            $display("FAIL mask_blocked: got %h / %0d events required 0 / 0", m_ev_obs, m_ev_cnt - m_ev_before);
        end
        n_cmp++;
        if (ev_obs !== {4'b0100, 7'h3C, 7'h00, 4'd2}) begin
            n_err++;
            $display("FAIL mask_open: got %h required %h", ev_obs, {4'b0100, 7'h3C, 7'h00, 4'd2});
        end
        drive(8'h80); idle();
        drive(8'h3C); idle();
        drive(8'h11); idle();
        n_cmp++;
        if (m_ev_obs !== {4'b0100, 7'h3C, 7'h11, 4'd0}) begin
            n_err++;
            $display("FAIL mask_ch0: got %h required %h", m_ev_obs, {4'b0100, 7'h3C, 7'h11, 4'd0});
        end
    endtask

    task automatic test_drop_saturation();
        do_reset();
        for (int i = 0; i < 254; i++) drive(8'h55);
        idle();
        n_cmp++;
        if (drop_cnt !== 8'hFE) begin
            n_err++;
            $display("FAIL drop_254: got %h required FE", drop_cnt);
        end
        for (int i = 0; i < 46; i++) drive(8'h2A);
        idle();
        n_cmp++;
        if (drop_cnt !== 8'hFF) begin
            n_err++;
            $display("FAIL drop_saturate: got %h required FF", drop_cnt);
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        drive(8'hFE); drive(8'h90); idle();
        rst_n = 1'b0;
        @(negedge clk32);
        @(negedge clk32);
        rst_n = 1'b1;
        ev_before = ev_cnt;
        drive(8'h40); idle(); idle();
        n_cmp++;
        if (drop_cnt !== 8'd1 || ev_cnt - ev_before !== 0 || ev_obs !== 22'd0) begin
            n_err++;
            $display("FAIL reset_mid: got drop %0d events %0d out %h required 1, 0, 0",
                     drop_cnt, ev_cnt - ev_before, ev_obs);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_interrupted_message();
        test_realtime();
        test_pressure();
        test_back_to_back();
        test_silent_types();
        test_sysex();
        test_channel_mask();
        test_drop_saturation();
        test_reset_mid_message();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
